gate_response_checker: RTL and testbench

Synthesizable response checker for the structural gate set (AND, OR, XOR, NOT). A stimulus source drives the gate inputs and the checker sees the same inputs plus the four gate outputs. It sits on the receive end of that stimulus/response pair: on each strobed sample it computes the expected truth-table result, compares it with the observed outputs, and keeps counts, per-gate sticky error flags and input-combination coverage. It reports done once all four {A,B} combinations have been checked.

---
 rtl/gate_response_checker.sv | 205 ++++++++++++++++++++
 tb/tb_gate_response_checker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// ---------------------------------------------------------------------------
// gate_response_checker
//
// Receive-side checker for the structural gate set (AND, OR, XOR, NOT).
// The checker sees the same A/B inputs the stimulus source drives, plus the
// four observed gate outputs. On every strobed sample taken while a session
// is running it computes the expected truth-table result and compares it
// with the observed outputs. It keeps pass/fail counts, sticky per-gate
// error flags and {A,B} input-combination coverage. The session ends once
// all four combinations have been seen.
//
// Optional feature macro: GATE_CHK_FIRST_ERR_EN
//    When defined, the first_err port and its register exist. first_err
//    latches {a,b,y_and,y_or,y_xor,y_not} of the first failing sample in a
//    session. When undefined, the port is absent and nothing else changes.
//
// Parameters
//    CNT_W        width of the pass and fail counters (legal range 2..16)
//
// Ports
//    clk          sole clock; all state changes on the rising edge
//    rst          synchronous, active-high reset
//    start        single-cycle pulse that begins or restarts a session
//    sample_valid current a/b/y_* values form one sample
//    a, b         gate inputs as driven by the stimulus source
//    y_and        observed AND output
//    y_or         observed OR output
//    y_xor        observed XOR output
//    y_not        observed NOT output (driven from A)
//    busy         high while a session is running
//    done         high once coverage is complete
//    pass_cnt     saturating count of fully correct samples
//    fail_cnt     saturating count of samples with any wrong output
//    cov_mask     bit {a,b} set once that combination was sampled
//    err_gate     sticky mismatch flags, order {not,xor,or,and}
//    error        OR of err_gate
//    first_err    {a,b,y_and,y_or,y_xor,y_not} of the first failure
//                 (GATE_CHK_FIRST_ERR_EN only)
// ---------------------------------------------------------------------------
module gate_response_checker #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sample_valid,
   input  logic             a,
   input  logic             b,
   input  logic             y_and,
   input  logic             y_or,
   input  logic             y_xor,
   input  logic             y_not,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [3:0]       cov_mask,
   output logic [3:0]       err_gate,
   output logic             error
`ifdef GATE_CHK_FIRST_ERR_EN
   ,
   output logic [5:0]       first_err
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state;
   state_t           next_state;

   logic [CNT_W-1:0] pass_q;
   logic [CNT_W-1:0] fail_q;
   logic [3:0]       cov_q;
   logic [3:0]       err_q;

   logic [3:0]       expected;
   logic [3:0]       observed;
   logic [3:0]       mismatch;
   logic [3:0]       sample_bit;
   logic [3:0]       cov_next;
   logic             sample_fire;
   logic             sample_fail;

   // Golden model of the gate set plus the per-gate mismatch vector. Bit
   // order everywhere is {not,xor,or,and} so mismatch maps directly onto
   // err_gate. sample_bit is the one-hot coverage bit for the current {a,b}.
   always_comb begin
      expected    = {~a, a ^ b, a | b, a & b};
      observed    = {y_not, y_xor, y_or, y_and};
      mismatch    = observed ^ expected;
      sample_bit  = 4'b0001 << {a, b};
      cov_next    = cov_q | sample_bit;
      sample_fail = |mismatch;
   end

   // A sample is only consumed while running. A coincident start wins over
   // the sample, so the sample is dropped and the session clears instead.
   always_comb begin
      sample_fire = (state == RUN) && sample_valid && !start;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. start restarts from any state. RUN leaves for DONE on
   // the same edge that consumes the sample completing coverage, so done and
   // the final count update become visible together.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = RUN;
            end
         end
         RUN: begin
            if (start) begin
               next_state = RUN;
            end else if (sample_fire && (cov_next == 4'hF)) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (start) begin
               next_state = RUN;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Status outputs decoded purely from the state register, so there is no
   // combinational path from any input to busy or done.
   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   // Result registers. rst and start both clear everything; start is the
   // per-session clear. Counters stop at all-ones instead of wrapping so a
   // long run never reports a misleadingly small count.
   always_ff @(posedge clk) begin
      if (rst || start) begin
         pass_q <= '0;
         fail_q <= '0;
         cov_q  <= 4'h0;
         err_q  <= 4'h0;
      end else if (sample_fire) begin
         cov_q <= cov_next;
         err_q <= err_q | mismatch;
         if (sample_fail) begin
            if (fail_q != CNT_MAX) begin
               fail_q <= fail_q + 1'b1;
            end
         end else begin
            if (pass_q != CNT_MAX) begin
               pass_q <= pass_q + 1'b1;
            end
         end
      end
   end

`ifdef GATE_CHK_FIRST_ERR_EN
   logic [5:0] first_q;

   // Capture of the first failing sample. fail_q is cleared on every session
   // start and saturates rather than wrapping, so fail_q == 0 reliably means
   // no failure has been recorded yet in this session.
   always_ff @(posedge clk) begin
      if (rst || start) begin
         first_q <= 6'h00;
      end else if (sample_fire && sample_fail && (fail_q == '0)) begin
         first_q <= {a, b, y_and, y_or, y_xor, y_not};
      end
   end

   always_comb begin
      first_err = first_q;
   end
`endif

   // Result outputs straight from the registers.
   always_comb begin
      pass_cnt = pass_q;
      fail_cnt = fail_q;
      cov_mask = cov_q;
      err_gate = err_q;
      error    = |err_q;
   end

endmodule

// File: tb/tb_gate_response_checker.sv
// ---------------------------------------------------------------------------
// tb_gate_response_checker
//
// Directed bench for gate_response_checker. dut uses the default counter
// width; dut_sat uses CNT_W = 2 to exercise counter saturation. Both share
// the data inputs and reset but have their own start/sample_valid strobes.
// Inputs change on the falling edge and outputs are compared on the falling
// edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_gate_response_checker;

   logic       clk;
   logic       rst;
   logic       start;
   logic       sample_valid;
   logic       start_sat;
   logic       sample_valid_sat;
   logic       a;
   logic       b;
   logic       y_and;
   logic       y_or;
   logic       y_xor;
   logic       y_not;

   logic       busy;
   logic       done;
   logic [7:0] pass_cnt;
   logic [7:0] fail_cnt;
   logic [3:0] cov_mask;
   logic [3:0] err_gate;
   logic       error;

   logic       busy_sat;
   logic       done_sat;
   logic [1:0] pass_cnt_sat;
   logic [1:0] fail_cnt_sat;
   logic [3:0] cov_mask_sat;
   logic [3:0] err_gate_sat;
   logic       error_sat;

`ifdef GATE_CHK_FIRST_ERR_EN
   logic [5:0] first_err;
   logic [5:0] first_err_sat;
`endif

   int vectors;
   int miscompares;

   gate_response_checker #(.CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .sample_valid (sample_valid),
      .a            (a),
      .b            (b),
      .y_and        (y_and),
      .y_or         (y_or),
      .y_xor        (y_xor),
      .y_not        (y_not),
      .busy         (busy),
      .done         (done),
      .pass_cnt     (pass_cnt),
      .fail_cnt     (fail_cnt),
      .cov_mask     (cov_mask),
      .err_gate     (err_gate),
      .error        (error)
`ifdef GATE_CHK_FIRST_ERR_EN
      ,
      .first_err    (first_err)
`endif
   );

   gate_response_checker #(.CNT_W(2)) dut_sat (
      .clk          (clk),
      .rst          (rst),
      .start        (start_sat),
      .sample_valid (sample_valid_sat),
      .a            (a),
      .b            (b),
      .y_and        (y_and),
      .y_or         (y_or),
      .y_xor        (y_xor),
      .y_not        (y_not),
      .busy         (busy_sat),
      .done         (done_sat),
      .pass_cnt     (pass_cnt_sat),
      .fail_cnt     (fail_cnt_sat),
      .cov_mask     (cov_mask_sat),
      .err_gate     (err_gate_sat),
      .error        (error_sat)
`ifdef GATE_CHK_FIRST_ERR_EN
      ,
      .first_err    (first_err_sat)
`endif
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one cycle of inputs at the falling edge. The gate outputs are the
   // correct truth-table values with selected bits inverted by flip, which is
   // ordered {not,xor,or,and}. sel picks which instance receives the strobes.
   task automatic applyStimulus(input logic av, input logic bv,
                                input logic [3:0] flip, input logic vl,
                                input logic st, input logic sel);
      @(negedge clk);
      a     = av;
      b     = bv;
      y_and = (av & bv) ^ flip[0];
      y_or  = (av | bv) ^ flip[1];
      y_xor = (av ^ bv) ^ flip[2];
      y_not = (~av)     ^ flip[3];
      sample_valid     = sel ? 1'b0 : vl;
      start            = sel ? 1'b0 : st;
      sample_valid_sat = sel ? vl : 1'b0;
      start_sat        = sel ? st : 1'b0;
   endtask

   // One falling edge with no strobes, so the previous cycle's edge has
   // been consumed and outputs can be compared.
   task automatic idleCycle();
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      rst              = 1'b1;
      start            = 1'b0;
      sample_valid     = 1'b0;
      start_sat        = 1'b0;
      sample_valid_sat = 1'b0;
      a = 1'b0; b = 1'b0;
      y_and = 1'b0; y_or = 1'b0; y_xor = 1'b0; y_not = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idleCycle();
      checkOutput("reset_busy",  16'(busy),     16'd0);
      checkOutput("reset_done",  16'(done),     16'd0);
      checkOutput("reset_pass",  16'(pass_cnt), 16'd0);
      checkOutput("reset_fail",  16'(fail_cnt), 16'd0);
      checkOutput("reset_cov",   16'(cov_mask), 16'd0);
      checkOutput("reset_err",   16'(err_gate), 16'd0);
      checkOutput("reset_error", 16'(error),    16'd0);
`ifdef GATE_CHK_FIRST_ERR_EN
      checkOutput("reset_first", 16'(first_err), 16'd0);
`endif

      // Full clean coverage 00,01,10,11 back to back
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      idleCycle();
      checkOutput("start_busy", 16'(busy), 16'd1);
      checkOutput("start_done", 16'(done), 16'd0);
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("full_pass", 16'(pass_cnt), 16'd4);
      checkOutput("full_fail", 16'(fail_cnt), 16'd0);
      checkOutput("full_cov",  16'(cov_mask), 16'hF);
      checkOutput("full_err",  16'(err_gate), 16'd0);
      checkOutput("full_done", 16'(done),     16'd1);
      checkOutput("full_busy", 16'(busy),     16'd0);

      // DONE ignores further samples, even bad ones
      applyStimulus(1'b0, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("hold_pass", 16'(pass_cnt), 16'd4);
      checkOutput("hold_fail", 16'(fail_cnt), 16'd0);
      checkOutput("hold_err",  16'(err_gate), 16'd0);

      // XOR fault on 11, then an AND fault on 00
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("xor_fail",  16'(fail_cnt), 16'd1);
      checkOutput("xor_pass",  16'(pass_cnt), 16'd0);
      checkOutput("xor_err",   16'(err_gate), 16'b0100);
      checkOutput("xor_error", 16'(error),    16'd1);
      checkOutput("xor_cov",   16'(cov_mask), 16'b1000);
`ifdef GATE_CHK_FIRST_ERR_EN
      checkOutput("xor_first", 16'(first_err), 16'b111110);
`endif
      applyStimulus(1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("and_fail", 16'(fail_cnt), 16'd2);
      checkOutput("and_err",  16'(err_gate), 16'b0101);
`ifdef GATE_CHK_FIRST_ERR_EN
      checkOutput("and_first_kept", 16'(first_err), 16'b111110);
`endif

      // Restart mid-RUN with a coincident sample: the clear wins
      applyStimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0);
      idleCycle();
      checkOutput("restart_pass",  16'(pass_cnt), 16'd0);
      checkOutput("restart_fail",  16'(fail_cnt), 16'd0);
      checkOutput("restart_cov",   16'(cov_mask), 16'd0);
      checkOutput("restart_err",   16'(err_gate), 16'd0);
      checkOutput("restart_error", 16'(error),    16'd0);
      checkOutput("restart_busy",  16'(busy),     16'd1);
`ifdef GATE_CHK_FIRST_ERR_EN
      checkOutput("restart_first", 16'(first_err), 16'd0);
`endif

      // Partial coverage with a repeated combination: 00, 00, 01
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("part_pass", 16'(pass_cnt), 16'd3);
      checkOutput("part_cov",  16'(cov_mask), 16'b0011);
      checkOutput("part_busy", 16'(busy),     16'd1);
      checkOutput("part_done", 16'(done),     16'd0);

      // Finish coverage with 10 and 11
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("end_pass", 16'(pass_cnt), 16'd5);
      checkOutput("end_done", 16'(done),     16'd1);

      // Reset while DONE, then samples without start are ignored
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_done", 16'(done),     16'd0);
      checkOutput("rst_busy", 16'(busy),     16'd0);
      checkOutput("rst_pass", 16'(pass_cnt), 16'd0);
      applyStimulus(1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
      idleCycle();
      checkOutput("idle_pass",  16'(pass_cnt), 16'd0);
      checkOutput("idle_fail",  16'(fail_cnt), 16'd0);
      checkOutput("idle_cov",   16'(cov_mask), 16'd0);
      checkOutput("idle_err",   16'(err_gate), 16'd0);
      checkOutput("idle_error", 16'(error),    16'd0);
      checkOutput("idle_busy",  16'(busy),     16'd0);

      // CNT_W = 2 instance: five clean 00 samples saturate at 3
      applyStimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
      end
      idleCycle();
      checkOutput("sat_pass", 16'(pass_cnt_sat), 16'd3);
      checkOutput("sat_fail", 16'(fail_cnt_sat), 16'd0);
      checkOutput("sat_cov",  16'(cov_mask_sat), 16'b0001);
      checkOutput("sat_done", 16'(done_sat),     16'd0);
      checkOutput("sat_busy", 16'(busy_sat),     16'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
